// File: rtl/vga_text_scan.sv
// Text-mode VGA scan-out: 8x16 character cells, two cells per 32-bit VRAM word, 3-tick pixel pipeline.
// Define CURSOR_EN to add a blinking underline cursor (cursor_x/cursor_y inputs).
module vga_text_scan #(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = 640,
  parameter int V_VIS   = 480
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef CURSOR_EN
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
`endif
  output logic [10:0] vga_addr,
  input  logic [31:0] vga_dout,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] rgb,
  output logic        frame_start
);
  // Blanking follows the 640x480@60 proportions: 16/96/48 horizontally, 10/2/33 vertically.
  localparam int H_TOT  = H_VIS + 160;
  localparam int V_TOT  = V_VIS + 45;
  localparam int HS_BEG = H_VIS + 16;
  localparam int HS_END = H_VIS + 111;
  localparam int VS_BEG = V_VIS + 10;
  localparam int VS_END = V_VIS + 11;
  localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div;
  logic          tick;
  logic [9:0]    h, v;
  logic          raw_hs, raw_vs, raw_de;
  logic [6:0]    col;
  logic [4:0]    row;
  logic [10:0]   word_addr;
  logic          cur_hit, blink;

  logic          s0_col0, s0_hs, s0_vs, s0_de, s0_cur;
  logic [3:0]    s0_line;
  logic [2:0]    s0_px;
  logic [15:0]   half;
  logic [3:0]    s1_fg, s1_bg;
  logic [2:0]    s1_px;
  logic          s1_hs, s1_vs, s1_de, s1_cur;
  logic          pix_bit;

  function automatic logic [11:0] pal(input logic [3:0] irgb);
    logic [3:0] on_lvl, off_lvl;
    on_lvl  = irgb[3] ? 4'hF : 4'hA;
    off_lvl = irgb[3] ? 4'h5 : 4'h0;
    return {irgb[2] ? on_lvl : off_lvl,
            irgb[1] ? on_lvl : off_lvl,
            irgb[0] ? on_lvl : off_lvl};
  endfunction

  assign tick = (div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else begin
      div <= tick ? '0 : div + DW'(1);
      if (tick) begin
        if (h == 10'(H_TOT - 1)) begin
          h <= '0;
          v <= (v == 10'(V_TOT - 1)) ? '0 : v + 10'd1;
        end else begin
          h <= h + 10'd1;
        end
      end
    end
  end

  assign raw_hs = !((h >= 10'(HS_BEG)) && (h <= 10'(HS_END)));
  assign raw_vs = !((v >= 10'(VS_BEG)) && (v <= 10'(VS_END)));
  assign raw_de = (h < 10'(H_VIS)) && (v < 10'(V_VIS));

  assign col = h[9:3];
  assign row = v[8:4];
  // row*40 as row*32 + row*8
  assign word_addr = {1'b0, row, 5'b0} + {3'b0, row, 3'b0} + {5'b0, col[6:1]};

`ifdef CURSOR_EN
  logic [4:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           frame_cnt <= '0;
    else if (frame_start) frame_cnt <= frame_cnt + 5'd1;
  end

  assign blink   = frame_cnt[4];
  assign cur_hit = (col == cursor_x) && (row == cursor_y) && (v[3:1] == 3'b111);
`else
  assign blink   = 1'b0;
  assign cur_hit = 1'b0;
`endif

  assign half    = s0_col0 ? vga_dout[31:16] : vga_dout[15:0];
  assign pix_bit = font_data[3'd7 - s1_px] | (s1_cur & blink);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      vga_addr    <= '0;
      s0_col0     <= 1'b0;
      s0_line     <= '0;
      s0_px       <= '0;
      s0_hs       <= 1'b1;
      s0_vs       <= 1'b1;
      s0_de       <= 1'b0;
      s0_cur      <= 1'b0;
      font_addr   <= '0;
      s1_fg       <= '0;
      s1_bg       <= '0;
      s1_px       <= '0;
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      s1_de       <= 1'b0;
      s1_cur      <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      rgb         <= '0;
    end else begin
      frame_start <= tick && (h == 10'd0) && (v == 10'd0);
      if (tick) begin
        if (raw_de) vga_addr <= word_addr;
        s0_col0   <= col[0];
        s0_line   <= v[3:0];
        s0_px     <= h[2:0];
        s0_hs     <= raw_hs;
        s0_vs     <= raw_vs;
        s0_de     <= raw_de;
        s0_cur    <= cur_hit;

        font_addr <= {half[7:0], s0_line};
        s1_fg     <= half[11:8];
        s1_bg     <= half[15:12];
        s1_px     <= s0_px;
        s1_hs     <= s0_hs;
        s1_vs     <= s0_vs;
        s1_de     <= s0_de;
        s1_cur    <= s0_cur;

        hsync     <= s1_hs;
        vsync     <= s1_vs;
        de        <= s1_de;
        rgb       <= s1_de ? pal(pix_bit ? s1_fg : s1_bg) : 12'h000;
      end
    end
  end
endmodule

// File: tb/tb_vga_text_scan.sv
// Scoreboard bench for vga_text_scan on a reduced 32x32 visible area (192x77 total) with CLK_DIV=2.
`timescale 1ns/1ps
module tb_vga_text_scan;
  localparam int CLK_DIV = 2;
  localparam int H_VIS   = 32;
  localparam int V_VIS   = 32;
  localparam int H_TOT   = H_VIS + 160;
  localparam int V_TOT   = V_VIS + 45;
  localparam int FRAME   = H_TOT * V_TOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] vga_addr;
  logic [31:0] vga_dout;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic        hsync, vsync, de, frame_start;
  logic [11:0] rgb;

  always #5 clk = ~clk;

  vga_text_scan #(.CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .V_VIS(V_VIS)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef CURSOR_EN
    .cursor_x(7'd127),
    .cursor_y(5'd31),
`endif
    .vga_addr(vga_addr),
    .vga_dout(vga_dout),
    .font_addr(font_addr),
    .font_data(font_data),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .rgb(rgb),
    .frame_start(frame_start)
  );

  logic [31:0] vram [0:2047];
  assign vga_dout = vram[vga_addr];

  function automatic logic [7:0] font_rom(input logic [11:0] a);
    case (a[11:4])
      8'h41:   return 8'h80;
      8'hFF:   return 8'hFF;
      8'h07:   return {a[3:0], ~a[3:0]};
      default: return 8'h00;
    endcase
  endfunction
  assign font_data = font_rom(font_addr);

  typedef struct {
    int          h;
    int          v;
    int          f;
    int          kind;  // 0: {hsync,vsync,de,rgb}  1: vga_addr  2: font_addr
    logic [31:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
    string       name;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];

  int   checks = 0;
  int   failures = 0;
  int   ccnt = 0;
  int   tidx = 0;
  int   fs_cnt = 0;
  int   hs_low = 0, vs_low = 0, de_cnt = 0, blank_lit = 0;
  bit   phase1 = 1'b1;
  event tick_ev;

  function automatic logic [31:0] px(input bit hs, input bit vs, input bit d, input logic [11:0] c);
    return {17'b0, hs, vs, d, c};
  endfunction

  function automatic void add(input int h, input int v, input int f, input int kind,
                              input logic [31:0] exp, input string name);
    vec_t e;
    e.h = h; e.v = v; e.f = f; e.kind = kind; e.exp = exp; e.name = name;
    tbl.push_back(e);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (tick %0d)", nm, act, exp, tidx);
    end
  endtask

  task automatic wait_tidx(input int target, input string nm);
    int budget;
    budget = 0;
    while (tidx < target && budget < 4 * CLK_DIV * FRAME) begin
      @(posedge clk); #2;
      budget++;
    end
    if (tidx < target) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s: tick %0d never reached %0d", nm, tidx, target);
    end
  endtask

  // Bench-side tick reference: the divider restarts at 0 when reset is released.
  initial forever begin
    @(posedge clk); #1;
    if (!rst_n) begin
      ccnt = 0;
      tidx = 0;
    end else begin
      ccnt++;
      if (ccnt == CLK_DIV) begin
        ccnt = 0;
        tidx++;
        ->tick_ev;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (frame_start === 1'b1) fs_cnt++;
  end

  // Monitor: pops expectations whose output tick has arrived.
  initial forever begin
    @(tick_ev);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due < tidx) begin
        checks++;
        failures++;
        $display("FAIL %s: expectation overdue, due %0d now %0d", sb[i].name, sb[i].due, tidx);
        sb.delete(i);
      end else if (sb[i].due == tidx) begin
        case (sb[i].kind)
          0:       check(sb[i].name, {17'b0, hsync, vsync, de, rgb}, sb[i].exp);
          1:       check(sb[i].name, {21'b0, vga_addr}, sb[i].exp);
          default: check(sb[i].name, {20'b0, font_addr}, sb[i].exp);
        endcase
        sb.delete(i);
      end
    end
    if (phase1 && tidx == 2) check("dark_before_latency", {19'b0, de, rgb}, 32'h0);
    if (phase1 && tidx >= 3 && tidx < 3 + FRAME) begin
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (de) de_cnt++;
      if (!de && rgb != 12'h000) blank_lit++;
    end
  end

  initial begin
    int  n;
    sb_t s;
    for (int i = 0; i < 2048; i++) vram[i] = 32'h0;
    vram[0]  = 32'h1F41_2E41;
    vram[1]  = 32'hFFFF_FFFF;
    vram[40] = 32'h9000_3C07;

    add(0,   0,  0, 0, px(1,1,1,12'hFF5), "pix_h0_v0");
    add(0,   0,  0, 1, 32'd0,             "addr_h0_v0");
    add(1,   0,  0, 0, px(1,1,1,12'h0A0), "pix_h1_bg");
    add(7,   0,  0, 0, px(1,1,1,12'h0A0), "pix_h7_bg");
    add(8,   0,  0, 0, px(1,1,1,12'hFFF), "pix_h8_fg_hi");
    add(8,   0,  0, 1, 32'd0,             "addr_h8_same_word");
    add(8,   0,  0, 2, 32'h410,           "font_h8");
    add(9,   0,  0, 0, px(1,1,1,12'h00A), "pix_h9_bg_hi");
    add(16,  0,  0, 1, 32'd1,             "addr_h16");
    add(32,  0,  0, 0, px(1,1,0,12'h000), "pix_blank_forced_zero");
    add(48,  0,  0, 0, px(0,1,0,12'h000), "hsync_first_low");
    add(143, 0,  0, 0, px(0,1,0,12'h000), "hsync_last_low");
    add(144, 0,  0, 0, px(1,1,0,12'h000), "hsync_release");
    add(16,  3,  0, 0, px(1,1,1,12'hFFF), "pix_all_ones");
    add(16,  3,  0, 2, 32'hFF3,           "font_code_ff_line3");
    add(15,  5,  0, 0, px(1,1,1,12'h00A), "pix_h15_line5");
    add(31,  15, 0, 0, px(1,1,1,12'hFFF), "pix_last_vis_row0");
    add(0,   16, 0, 0, px(1,1,1,12'h0AA), "pix_row1_bg");
    add(0,   16, 0, 1, 32'd40,            "addr_row1");
    add(4,   16, 0, 0, px(1,1,1,12'hF55), "pix_row1_fg");
    add(8,   16, 0, 0, px(1,1,1,12'h55F), "pix_row1_hi_bg");
    add(0,   21, 0, 0, px(1,1,1,12'h0AA), "pix_line5_px0");
    add(0,   21, 0, 2, 32'h075,           "font_code07_line5");
    add(1,   21, 0, 0, px(1,1,1,12'hF55), "pix_line5_px1");
    add(31,  31, 0, 1, 32'd41,            "addr_last_visible");
    add(0,   32, 0, 0, px(1,1,0,12'h000), "pix_vblank_zero");
    add(100, 40, 0, 1, 32'd41,            "addr_hold_blank");
    add(0,   42, 0, 0, px(1,0,0,12'h000), "vsync_first_low");
    add(50,  43, 0, 0, px(0,0,0,12'h000), "vsync_hsync_low");
    add(0,   44, 0, 0, px(1,1,0,12'h000), "vsync_release");
    add(191, 76, 0, 0, px(1,1,0,12'h000), "pix_frame_last");
    add(191, 76, 0, 1, 32'd41,            "addr_frame_last");
    add(0,   0,  1, 0, px(1,1,1,12'hFF5), "pix_wrap_h0_v0");
    add(0,   0,  1, 1, 32'd0,             "addr_wrap");

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      n = tbl[i].f * FRAME + tbl[i].v * H_TOT + tbl[i].h;
      wait_tidx(n, tbl[i].name);
      s.due  = n + ((tbl[i].kind == 0) ? 3 : (tbl[i].kind == 1) ? 1 : 2);
      s.kind = tbl[i].kind;
      s.exp  = tbl[i].exp;
      s.name = tbl[i].name;
      sb.push_back(s);
    end

    wait_tidx(FRAME + 8, "frame_end");
    phase1 = 1'b0;
    check("hsync_low_ticks",   32'(hs_low),    32'(96 * V_TOT));
    check("vsync_low_ticks",   32'(vs_low),    32'(2 * H_TOT));
    check("de_ticks",          32'(de_cnt),    32'(H_VIS * V_VIS));
    check("rgb_lit_in_blank",  32'(blank_lit), 32'd0);
    check("frame_start_count", 32'(fs_cnt),    32'd2);

    wait_tidx(FRAME + 10 * H_TOT + 20, "reset_point");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_immediate", {hsync, vsync, de, rgb, vga_addr, font_addr, frame_start},
          {1'b1, 1'b1, 1'b0, 12'h000, 11'd0, 12'h000, 1'b0});
    repeat (3) @(negedge clk);
    check("reset_held", {hsync, vsync, de, rgb, vga_addr, font_addr, frame_start},
          {1'b1, 1'b1, 1'b0, 12'h000, 11'd0, 12'h000, 1'b0});
    rst_n = 1'b1;

    wait_tidx(H_VIS + 16 + 2, "hsync_pre_fall");
    check("hsync_before_fall", {31'b0, hsync}, 32'd1);
    wait_tidx(H_VIS + 16 + 3, "hsync_fall");
    check("hsync_fall_after_restart", {31'b0, hsync}, 32'd0);
    check("frame_start_after_restart", 32'(fs_cnt), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
